cci_mpf_prim_rsp_sorter: RTL and testbench
==========================================

Name: cci_mpf_prim_rsp_sorter

Overview:
- Parametrised in-order response sorter with metadata preservation for CCI-P read responses.
- Requests allocate groups of 1..MAX_ALLOC_PER_CYCLE consecutive slots and store one metadata word per group.
- Responses arrive out of order, tagged by slot index. They are released strictly in allocation order, with group metadata replicated on every beat and EOP generated internally.
- Sits between an AFU-side shim and the FIU-side buffer. It is the flat-port successor of the shim-embedded ROB, used when several shims need sorted, Mdata-restored channels.

Parameters:
- N_ENTRIES, 128, slot count; power of 2, minimum 8.
- N_DATA_BITS, 512, payload width per beat.
- N_META_BITS, 16, per-group metadata width.
- MAX_ALLOC_PER_CYCLE, 4, maximum beats per group; power of 2, at most N_ENTRIES/4.
- MIN_FREE_SLOTS, 8, reserve kept free when notFull is deasserted (almost-full slack).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active high
- alloc  in  $clog2(MAX_ALLOC_PER_CYCLE)+1  beats to allocate this cycle; 0 means no allocation.
- allocMeta  in  N_META_BITS  metadata for the group.
- allocIdx  out  $clog2(N_ENTRIES)  base slot of the group allocated this cycle.
- notFull  out  1  registered; room remains beyond the reserve.
- enqData_en  in  1  response beat valid.
- enqDataIdx  in  $clog2(N_ENTRIES)  slot to fill (base + beat offset).
- enqData  in  N_DATA_BITS  response payload.
- deq_en  in  1  pop the head; legal only when notEmpty.
- notEmpty  out  1  head beat valid in the output register.
- first  out  N_DATA_BITS  head payload.
- firstMeta  out  N_META_BITS  group metadata, present on every beat.
- firstBeat  out  $clog2(MAX_ALLOC_PER_CYCLE)  beat number within the group.
- firstEop  out  1  head is the last beat of its group.
- occupancy  out  $clog2(N_ENTRIES)+1  allocated, not yet dequeued slots.

Behaviour:
- Reset (async assert, sync release):
  - alloc/oldest pointers 0; all slot valid bits 0.
  - notFull 0 for the first cycle after release, then 1.
  - notEmpty 0, occupancy 0, firstEop 0.
  - first, firstMeta and firstBeat are don't-care while notEmpty is 0.
- Pointers are $clog2(N_ENTRIES)+1 bits wide; the MSB disambiguates full from empty. occupancy = allocPtr - oldestPtr, modulo 2^(idx+1).
- Allocation:
  - allocIdx = allocPtr[idx-1:0], combinational, valid in the same cycle as alloc.
  - allocPtr advances by alloc.
  - Each slot in the group records its beat number and group length minus 1.
  - The base slot stores allocMeta. Groups may wrap around the end of the index space.
- notFull is registered: next value is (N_ENTRIES - occupancy_next) >= MIN_FREE_SLOTS + MAX_ALLOC_PER_CYCLE.
- Requesters may keep allocating for up to MIN_FREE_SLOTS/MAX_ALLOC_PER_CYCLE cycles after notFull falls.
- Allocating beyond the free space is illegal and flagged by a simulation assertion.
- Enqueue:
  - Writes the payload and sets the slot's valid bit.
  - Any slot order is accepted.
  - Enqueue and dequeue of different slots in the same cycle are both honoured.
- Release pipeline:
  - Stage A reads slot oldestPtr + k from the data RAM (1-cycle latency); stage B is the output register.
  - An enq at cycle t to the head slot, with an empty pipe, gives notEmpty at t+2.
  - Back-to-back deq sustains 1 beat/cycle when successive slots are valid.
- Meta tracking:
  - A beat-0 head loads firstMeta from the base slot and latches it as group meta.
  - Beats greater than 0 reuse the latched group meta.
  - firstEop = (firstBeat == stored length-1).
- deq_en clears the slot's valid bit and advances oldestPtr by 1. Occupancy and notFull update on the following cycle.
- Same-cycle alloc and deq: occupancy_next = occupancy + alloc - deq_en.
- deq_en while notEmpty is 0 is ignored and flagged by an assertion.
- Reset mid-operation discards all slots; no response is emitted after release until it is newly allocated and enqueued.

Optional Feature:
- CCI_MPF_RSP_SORTER_CHECK_EN defined:
  - Adds a sticky output `error` (1 bit, reset 0) and a 2-bit sticky `errorCode`, latched on the first fault only.
  - Code 1: enq to an already-valid slot.
  - Code 2: enq to a slot outside [oldestPtr, allocPtr).
  - Code 3: alloc exceeding free space.
  - Faulting enqs are dropped.
- Undefined: the ports are absent, no checking logic is present, and faulting enqs write normally.

Test Plan:
- Configuration for all scenarios: N_ENTRIES=16, MAX_ALLOC=4, MIN_FREE=2.
- Single beat: alloc=1 (meta 0xA5) -> allocIdx=0; enq idx 0 at t -> notEmpty at t+2, firstMeta=0xA5, firstBeat=0, firstEop=1.
- Reverse order: alloc=4 (meta 0x11); enq idx 3,2,1,0 over 4 cycles; deq held high:
  - Beats 0,1,2,3 appear on consecutive cycles, all with firstMeta=0x11.
  - firstEop is 1 only on beat 3.
- Head blocking: allocs of 1 (meta 1) and 1 (meta 2); enq idx 1 only -> notEmpty stays 0 for 10 cycles; enq idx 0 -> meta 1 then meta 2 released.
- Full and wrap:
  - Allocate groups of 4 until notFull=0, which occurs with occupancy 12 -> two further allocs of 1 are accepted.
  - Drain all; allocate 4 starting at idx 14 -> slots 14,15,0,1 are released in order.
- Reset mid-flight: 6 slots allocated, 3 enqueued, assert reset -> notEmpty=0, occupancy=0, allocIdx=0; first alloc after release returns idx 0.
- Checker (macro defined): enq idx 5 twice -> error=1, errorCode=1; a later out-of-range enq leaves errorCode at 1.

Source files
------------

// File: rtl/cci_mpf_prim_rsp_sorter.sv
// In-order sorter for out-of-order CCI-P read responses with per-group metadata replay.
// Optional fault checker: define CCI_MPF_RSP_SORTER_CHECK_EN to add error/errorCode.

module cci_mpf_prim_rsp_sorter #(
    parameter int N_ENTRIES           = 128,
    parameter int N_DATA_BITS         = 512,
    parameter int N_META_BITS         = 16,
    parameter int MAX_ALLOC_PER_CYCLE = 4,
    parameter int MIN_FREE_SLOTS      = 8,
    localparam int IW = $clog2(N_ENTRIES),
    localparam int PW = IW + 1,
    localparam int AW = $clog2(MAX_ALLOC_PER_CYCLE) + 1,
    localparam int BW = $clog2(MAX_ALLOC_PER_CYCLE)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [AW-1:0]          alloc,
    input  logic [N_META_BITS-1:0] allocMeta,
    output logic [IW-1:0]          allocIdx,
    output logic                   notFull,
    input  logic                   enqData_en,
    input  logic [IW-1:0]          enqDataIdx,
    input  logic [N_DATA_BITS-1:0] enqData,
    input  logic                   deq_en,
    output logic                   notEmpty,
    output logic [N_DATA_BITS-1:0] first,
    output logic [N_META_BITS-1:0] firstMeta,
    output logic [BW-1:0]          firstBeat,
    output logic                   firstEop,
    output logic [PW-1:0]          occupancy
`ifdef CCI_MPF_RSP_SORTER_CHECK_EN
    ,
    output logic                   error,
    output logic [1:0]             errorCode
`endif
);

    logic [PW-1:0]          allocPtr, oldestPtr;
    logic [PW-1:0]          allocPtr_nxt, oldestPtr_nxt, occ_nxt;
    logic [PW-1:0]          rdPtr;
    logic [IW-1:0]          rdIdx;
    logic [N_ENTRIES-1:0]   valid;
    logic                   eopReg;
    logic                   deq;
    logic                   enq_ok;
    logic                   load;

    logic [N_DATA_BITS-1:0] dataRam [N_ENTRIES];
    logic [N_META_BITS-1:0] metaRam [N_ENTRIES];
    logic [BW-1:0]          beatRam [N_ENTRIES];
    logic [BW-1:0]          lenRam  [N_ENTRIES];

    assign allocIdx      = allocPtr[IW-1:0];
    assign occupancy     = allocPtr - oldestPtr;
    assign deq           = deq_en & notEmpty;
    assign allocPtr_nxt  = allocPtr + PW'(alloc);
    assign oldestPtr_nxt = oldestPtr + PW'(deq);
    assign occ_nxt       = allocPtr_nxt - oldestPtr_nxt;

    // The output register always holds the head, so the next slot to read is one past it.
    assign rdPtr    = oldestPtr + PW'(notEmpty);
    assign rdIdx    = rdPtr[IW-1:0];
    assign load     = (!notEmpty || deq) && (rdPtr != allocPtr) && valid[rdIdx];
    assign firstEop = notEmpty & eopReg;

`ifdef CCI_MPF_RSP_SORTER_CHECK_EN
    logic [IW-1:0] enqOff;
    logic          fault_dup, fault_rng, fault_alloc;

    assign enqOff      = enqDataIdx - oldestPtr[IW-1:0];
    assign fault_dup   = enqData_en && valid[enqDataIdx];
    assign fault_rng   = enqData_en && ({1'b0, enqOff} >= occupancy);
    assign fault_alloc = PW'(alloc) > (PW'(N_ENTRIES) - occupancy);
    assign enq_ok      = enqData_en && !fault_dup && !fault_rng;
`else
    assign enq_ok      = enqData_en;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            allocPtr  <= '0;
            oldestPtr <= '0;
            valid     <= '0;
            notFull   <= 1'b0;
            notEmpty  <= 1'b0;
            eopReg    <= 1'b0;
`ifdef CCI_MPF_RSP_SORTER_CHECK_EN
            error     <= 1'b0;
            errorCode <= '0;
`endif
        end else begin
            allocPtr  <= allocPtr_nxt;
            oldestPtr <= oldestPtr_nxt;
            notFull   <= (N_ENTRIES - int'(occ_nxt)) >= (MIN_FREE_SLOTS + MAX_ALLOC_PER_CYCLE);
            if (deq)
                valid[oldestPtr[IW-1:0]] <= 1'b0;
            if (enq_ok)
                valid[enqDataIdx] <= 1'b1;
            if (load) begin
                notEmpty <= 1'b1;
                eopReg   <= (beatRam[rdIdx] == lenRam[rdIdx]);
            end else if (deq) begin
                notEmpty <= 1'b0;
            end
`ifdef CCI_MPF_RSP_SORTER_CHECK_EN
            if (!error) begin
                if (fault_dup) begin
                    error     <= 1'b1;
                    errorCode <= 2'd1;
                end else if (fault_rng) begin
                    error     <= 1'b1;
                    errorCode <= 2'd2;
                end else if (fault_alloc) begin
                    error     <= 1'b1;
                    errorCode <= 2'd3;
                end
            end
`endif
        end
    end

    // Storage and output payload carry no reset; they are qualified by valid/notEmpty.
    always_ff @(posedge clk) begin
        if (enq_ok)
            dataRam[enqDataIdx] <= enqData;
        for (int unsigned k = 0; k < MAX_ALLOC_PER_CYCLE; k++) begin
            if (AW'(k) < alloc) begin
                beatRam[allocIdx + IW'(k)] <= BW'(k);
                lenRam[allocIdx + IW'(k)]  <= BW'(alloc - AW'(1));
            end
        end
        if (alloc != '0)
            metaRam[allocIdx] <= allocMeta;
        if (load) begin
            first     <= dataRam[rdIdx];
            firstBeat <= beatRam[rdIdx];
            // Beat 0 picks up the group metadata; later beats keep the latched copy.
            if (beatRam[rdIdx] == '0)
                firstMeta <= metaRam[rdIdx];
        end
    end

`ifndef SYNTHESIS
    a_alloc_space: assert property (@(posedge clk) disable iff (reset)
        PW'(alloc) <= (PW'(N_ENTRIES) - occupancy))
        else $error("alloc exceeds free space");
    a_deq_empty: assert property (@(posedge clk) disable iff (reset)
        !(deq_en && !notEmpty))
        else $error("deq_en while notEmpty is low");
`endif

endmodule

// File: tb/tb_cci_mpf_prim_rsp_sorter.sv
// Self-checking bench for cci_mpf_prim_rsp_sorter: directed scenarios plus random traffic vs a queue model.

module tb_cci_mpf_prim_rsp_sorter;

    localparam int N  = 16;
    localparam int MA = 4;
    localparam int MF = 2;
    localparam int DB = 32;
    localparam int MB = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    alloc;
    logic [MB-1:0] allocMeta;
    logic [3:0]    allocIdx;
    logic          notFull;
    logic          enqData_en;
    logic [3:0]    enqDataIdx;
    logic [DB-1:0] enqData;
    logic          deq_en;
    logic          notEmpty;
    logic [DB-1:0] first;
    logic [MB-1:0] firstMeta;
    logic [1:0]    firstBeat;
    logic          firstEop;
    logic [4:0]    occupancy;
`ifdef CCI_MPF_RSP_SORTER_CHECK_EN
    logic          error;
    logic [1:0]    errorCode;
`endif

    cci_mpf_prim_rsp_sorter #(
        .N_ENTRIES(N),
        .N_DATA_BITS(DB),
        .N_META_BITS(MB),
        .MAX_ALLOC_PER_CYCLE(MA),
        .MIN_FREE_SLOTS(MF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .alloc(alloc),
        .allocMeta(allocMeta),
        .allocIdx(allocIdx),
        .notFull(notFull),
        .enqData_en(enqData_en),
        .enqDataIdx(enqDataIdx),
        .enqData(enqData),
        .deq_en(deq_en),
        .notEmpty(notEmpty),
        .first(first),
        .firstMeta(firstMeta),
        .firstBeat(firstBeat),
        .firstEop(firstEop),
        .occupancy(occupancy)
`ifdef CCI_MPF_RSP_SORTER_CHECK_EN
        ,
        .error(error),
        .errorCode(errorCode)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: allocation-ordered queue of beats plus per-slot fill state.
    typedef struct {
        int            slot;
        logic [MB-1:0] meta;
        int            beat;
        bit            eop;
    } beat_t;

    beat_t         q[$];
    bit            filled[N];
    logic [DB-1:0] mdata[N];
    int            aptr = 0;
    bit            nf_m = 1'b0;
    int            head_wait = 0;
    int            checks = 0;
    int            errors = 0;
    int            m_optr, m_off;
    bit            m_enq_ok;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            for (int i = 0; i < N; i++) filled[i] = 1'b0;
            aptr = 0;
            nf_m = 1'b0;
        end else begin
            m_optr   = (aptr - q.size() + N) % N;
            m_enq_ok = enqData_en;
`ifdef CCI_MPF_RSP_SORTER_CHECK_EN
            m_off = (int'(enqDataIdx) - m_optr + N) % N;
            if (filled[enqDataIdx] || m_off >= q.size()) m_enq_ok = 1'b0;
`endif
            if (deq_en && notEmpty && q.size() > 0) begin
                filled[q[0].slot] = 1'b0;
                void'(q.pop_front());
            end
            if (m_enq_ok) begin
                filled[enqDataIdx] = 1'b1;
                mdata[enqDataIdx]  = enqData;
            end
            for (int k = 0; k < int'(alloc); k++)
                q.push_back('{(aptr + k) % N, allocMeta, k, (k == int'(alloc) - 1)});
            aptr = (aptr + int'(alloc)) % N;
            nf_m = (N - q.size()) >= (MF + MA);
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            head_wait = 0;
        end else begin
            chk("occupancy", occupancy, q.size());
            chk("notFull", notFull, nf_m);
            chk("allocIdx", allocIdx, aptr);
            if (notEmpty === 1'b1) begin
                head_wait = 0;
                if (q.size() == 0) begin
                    chk("head_without_alloc", notEmpty, 0);
                end else begin
                    chk("head_filled", filled[q[0].slot], 1);
                    chk("first", first, mdata[q[0].slot]);
                    chk("firstMeta", firstMeta, q[0].meta);
                    chk("firstBeat", firstBeat, q[0].beat);
                    chk("firstEop", firstEop, q[0].eop);
                end
            end else begin
                chk("firstEop_idle", firstEop, 0);
                if (q.size() > 0 && filled[q[0].slot]) begin
                    head_wait++;
                    if (head_wait >= 2) chk("head_latency", notEmpty, 1);
                end else begin
                    head_wait = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int a, input int m, input bit e, input int idx,
                         input logic [DB-1:0] d, input bit dq);
        alloc      = 3'(a);
        allocMeta  = MB'(m);
        enqData_en = e;
        enqDataIdx = 4'(idx);
        enqData    = d;
        deq_en     = dq;
        tick();
        alloc      = '0;
        enqData_en = 1'b0;
        deq_en     = 1'b0;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        alloc      = '0;
        enqData_en = 1'b0;
        deq_en     = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && q.size() > 0; c++)
            drive(0, 0, 0, 0, '0, notEmpty === 1'b1);
        chk("drain_done", occupancy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, a, e, idx, base;
        bit dq;
        int perm[14];
        int pend[$];

        alloc = '0; allocMeta = '0; enqData_en = 1'b0; enqDataIdx = '0;
        enqData = '0; deq_en = 1'b0;

        // Reset state and notFull release timing
        do_reset();
        chk("rst_notEmpty", notEmpty, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_firstEop", firstEop, 0);
        chk("rst_notFull_first", notFull, 0);
        tick();
        chk("rst_notFull_after", notFull, 1);

        // Single beat
        chk("t1_allocIdx", allocIdx, 0);
        drive(1, 'hA5, 0, 0, '0, 0);
        drive(0, 0, 1, 0, 32'hCAFE0001, 0);
        chk("t1_empty_t1", notEmpty, 0);
        tick();
        chk("t1_notEmpty_t2", notEmpty, 1);
        chk("t1_meta", firstMeta, 'hA5);
        chk("t1_beat", firstBeat, 0);
        chk("t1_eop", firstEop, 1);
        chk("t1_data", first, 32'hCAFE0001);
        drive(0, 0, 0, 0, '0, 1);
        chk("t1_drained", notEmpty, 0);

        // Reverse-order fill of one 4-beat group
        do_reset();
        drive(4, 'h11, 0, 0, '0, 0);
        for (int i = 3; i >= 0; i--) drive(0, 0, 1, i, DB'(32'h200 + i), 0);
        chk("t2_empty_t1", notEmpty, 0);
        tick();
        for (int b = 0; b < 4; b++) begin
            chk("t2_valid", notEmpty, 1);
            chk("t2_beat", firstBeat, b);
            chk("t2_eop", firstEop, (b == 3));
            chk("t2_meta", firstMeta, 'h11);
            chk("t2_data", first, 32'h200 + b);
            drive(0, 0, 0, 0, '0, 1);
        end
        chk("t2_drained", notEmpty, 0);

        // Head blocking
        do_reset();
        drive(1, 1, 0, 0, '0, 0);
        drive(1, 2, 0, 0, '0, 0);
        drive(0, 0, 1, 1, 32'h301, 0);
        for (int c = 0; c < 10; c++) begin
            chk("t3_blocked", notEmpty, 0);
            tick();
        end
        drive(0, 0, 1, 0, 32'h300, 0);
        tick();
        chk("t3_head1", notEmpty, 1);
        chk("t3_meta1", firstMeta, 1);
        chk("t3_data1", first, 32'h300);
        drive(0, 0, 0, 0, '0, 1);
        chk("t3_head2", notEmpty, 1);
        chk("t3_meta2", firstMeta, 2);
        chk("t3_data2", first, 32'h301);
        chk("t3_eop2", firstEop, 1);
        drive(0, 0, 0, 0, '0, 1);
        chk("t3_drained", notEmpty, 0);

        // Fill to the almost-full threshold, use the reserve, then wrap
        do_reset();
        tick();
        n = 0;
        while (notFull === 1'b1 && n < 8) begin
            drive(4, 'h40 + n, 0, 0, '0, 0);
            n++;
        end
        chk("t4_groups", n, 3);
        chk("t4_full_occ", occupancy, 12);
        drive(1, 'h50, 0, 0, '0, 0);
        drive(1, 'h51, 0, 0, '0, 0);
        chk("t4_reserve_occ", occupancy, 14);
        for (int i = 0; i < 14; i++) perm[i] = i;
        for (int i = 13; i > 0; i--) begin
            int j, t;
            j = $urandom_range(0, i);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int i = 0; i < 14; i++)
            drive(0, 0, 1, perm[i], DB'(32'h400 + perm[i]), notEmpty === 1'b1);
        drain();
        chk("t4_wrap_base", allocIdx, 14);
        drive(4, 'h5A, 0, 0, '0, 0);
        drive(0, 0, 1, 1, 32'h501, 0);
        drive(0, 0, 1, 0, 32'h500, 0);
        drive(0, 0, 1, 15, 32'h50F, 0);
        drive(0, 0, 1, 14, 32'h50E, 0);
        k = 0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            if (notEmpty === 1'b1) begin
                chk("t4_wrap_beat", firstBeat, k);
                chk("t4_wrap_data", first, 32'h500 + ((14 + k) % 16));
                chk("t4_wrap_meta", firstMeta, 'h5A);
                k++;
                drive(0, 0, 0, 0, '0, 1);
            end else begin
                tick();
            end
        end
        chk("t4_wrap_count", k, 4);

        // Reset mid-flight
        do_reset();
        drive(4, 'h61, 0, 0, '0, 0);
        drive(2, 'h62, 0, 0, '0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, i, DB'(32'h600 + i), 0);
        tick();
        chk("t5_pre_reset_valid", notEmpty, 1);
        reset = 1'b1;
        #1;
        chk("t5_rst_notEmpty", notEmpty, 0);
        chk("t5_rst_occ", occupancy, 0);
        chk("t5_rst_allocIdx", allocIdx, 0);
        chk("t5_rst_eop", firstEop, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("t5_rel_notFull", notFull, 0);
        chk("t5_rel_allocIdx", allocIdx, 0);
        drive(1, 'h77, 0, 0, '0, 0);
        for (int c = 0; c < 4; c++) begin
            chk("t5_no_stale", notEmpty, 0);
            tick();
        end
        drive(0, 0, 1, 0, 32'h700, 0);
        tick();
        chk("t5_new_valid", notEmpty, 1);
        chk("t5_new_meta", firstMeta, 'h77);
        chk("t5_new_data", first, 32'h700);
        drive(0, 0, 0, 0, '0, 1);

        // Random traffic against the model
        do_reset();
        tick();
        pend.delete();
        for (int c = 0; c < 3000; c++) begin
            a = 0;
            if ($urandom % 2 == 1) begin
                a = $urandom_range(1, MA);
                if (a > N - q.size()) a = 0;
                if (notFull !== 1'b1 && $urandom % 4 != 0) a = 0;
            end
            e = 0;
            idx = 0;
            if (pend.size() > 0 && $urandom % 3 != 0) begin
                int j;
                j = $urandom_range(0, pend.size() - 1);
                idx = pend[j];
                pend.delete(j);
                e = 1;
            end
            dq = (notEmpty === 1'b1) && ($urandom % 4 != 0);
            base = aptr;
            drive(a, int'($urandom), e[0], idx, DB'($urandom), dq);
            for (int i = 0; i < a; i++) pend.push_back((base + i) % N);
        end
        for (int c = 0; c < 500 && (pend.size() > 0 || q.size() > 0); c++) begin
            e = 0;
            idx = 0;
            if (pend.size() > 0) begin
                idx = pend.pop_front();
                e = 1;
            end
            drive(0, 0, e[0], idx, DB'($urandom), notEmpty === 1'b1);
        end
        chk("t6_drained", occupancy, 0);

`ifdef CCI_MPF_RSP_SORTER_CHECK_EN
        // Sticky fault capture
        do_reset();
        chk("t7_error_rst", error, 0);
        drive(4, 'h71, 0, 0, '0, 0);
        drive(4, 'h72, 0, 0, '0, 0);
        drive(0, 0, 1, 5, 32'h805, 0);
        chk("t7_no_error", error, 0);
        drive(0, 0, 1, 5, 32'h905, 0);
        chk("t7_error", error, 1);
        chk("t7_code_dup", errorCode, 1);
        drive(0, 0, 1, 12, 32'h80C, 0);
        chk("t7_code_sticky", errorCode, 1);
        chk("t7_error_sticky", error, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
